// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory with registered read data.
// Each access is granted for one ISSUE cycle; reads add an RDWAIT cycle for the returned word.
module mem_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_wea,
  input  logic [15:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = requester B owns the access
  logic        last_q, last_d;     // 1 = B was served most recently
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        pick_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    if (a_req && b_req) pick_b = RR_ENABLE ? ~last_q : 1'b0;
    else                pick_b = b_req;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d = ISSUE;
          owner_d = pick_b;
          last_d  = pick_b;
          we_d    = pick_b ? b_we    : a_we;
          addr_d  = pick_b ? b_addr  : a_addr;
          wdata_d = pick_b ? b_wdata : a_wdata;
        end
      end
      ISSUE:   state_d = we_q ? IDLE : RDWAIT;
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data stay on the latched values outside ISSUE; only mem_wea qualifies a write.
  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    mem_wea  = 1'b0;
    mem_addr = addr_q;
    mem_din  = wdata_q;
    rdata    = mem_dout;
    busy     = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        a_gnt   = ~owner_q;
        b_gnt   = owner_q;
        mem_wea = we_q;
      end
      RDWAIT: begin
        a_rvalid = ~owner_q;
        b_rvalid = owner_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one round-robin and one fixed-priority instance against a
// transaction-level reference model, with directed scenarios followed by random traffic.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       a_req, a_we, b_req, b_we;
  logic [1:0][15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [1:0]       a_gnt, a_rvalid, b_gnt, b_rvalid, mem_wea, busy;
  logic [1:0][15:0] rdata, mem_addr, mem_din, mem_dout;

  mem_arbiter #(.RR_ENABLE(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]),
    .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]),
    .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
    .mem_wea(mem_wea[0]), .mem_dout(mem_dout[0]), .busy(busy[0])
  );

  mem_arbiter #(.RR_ENABLE(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]),
    .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]),
    .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
    .mem_wea(mem_wea[1]), .mem_dout(mem_dout[1]), .busy(busy[1])
  );

  // Memory stand-in per instance: registered read, read-before-write.
  bit [15:0] mem  [2][65536];
  bit [15:0] refm [2][65536];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mem_dout[i] <= mem[i][mem_addr[i]];
      if (mem_wea[i]) mem[i][mem_addr[i]] = mem_din[i];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: remaining busy cycles and position within the current access.
  int unsigned m_left [2];
  int unsigned m_pos  [2];
  bit          m_owner[2], m_we[2], m_last[2];
  logic [15:0] m_addr [2], m_wdata[2];
  bit          e_ga[2], e_gb[2], e_rva[2], e_rvb[2], e_wea[2], e_busy[2];

  task automatic model_step(input int i);
    bit win_b;
    if (m_left[i] != 0 && m_pos[i] == 0 && m_we[i]) refm[i][m_addr[i]] = m_wdata[i];
    if (reset) begin
      m_left[i] = 0; m_pos[i] = 0; m_last[i] = 1'b1; m_we[i] = 1'b0;
      m_addr[i] = 16'h0000; m_wdata[i] = 16'h0000;
    end else if (m_left[i] == 0) begin
      if (a_req[i] || b_req[i]) begin
        win_b      = b_req[i] && !(a_req[i] && (i == 1 || m_last[i]));
        m_owner[i] = win_b;
        m_last[i]  = win_b;
        m_we[i]    = win_b ? b_we[i]    : a_we[i];
        m_addr[i]  = win_b ? b_addr[i]  : a_addr[i];
        m_wdata[i] = win_b ? b_wdata[i] : a_wdata[i];
        m_left[i]  = m_we[i] ? 1 : 2;
        m_pos[i]   = 0;
      end
    end else begin
      m_left[i]--;
      m_pos[i]++;
    end
    e_busy[i] = (m_left[i] != 0);
    e_ga[i]   = e_busy[i] && m_pos[i] == 0 && !m_owner[i];
    e_gb[i]   = e_busy[i] && m_pos[i] == 0 &&  m_owner[i];
    e_wea[i]  = e_busy[i] && m_pos[i] == 0 &&  m_we[i];
    e_rva[i]  = e_busy[i] && m_pos[i] == 1 && !m_owner[i];
    e_rvb[i]  = e_busy[i] && m_pos[i] == 1 &&  m_owner[i];
  endtask

  task automatic compare_outputs(input int i);
    string p;
    p = $sformatf("u%0d.c%0d.", i, cyc);
    check_eq({p, "busy"},     16'(busy[i]),     16'(e_busy[i]));
    check_eq({p, "a_gnt"},    16'(a_gnt[i]),    16'(e_ga[i]));
    check_eq({p, "b_gnt"},    16'(b_gnt[i]),    16'(e_gb[i]));
    check_eq({p, "a_rvalid"}, 16'(a_rvalid[i]), 16'(e_rva[i]));
    check_eq({p, "b_rvalid"}, 16'(b_rvalid[i]), 16'(e_rvb[i]));
    check_eq({p, "mem_wea"},  16'(mem_wea[i]),  16'(e_wea[i]));
    check_eq({p, "mem_addr"}, mem_addr[i],      m_addr[i]);
    check_eq({p, "mem_din"},  mem_din[i],       m_wdata[i]);
    check_eq({p, "rdata_passthru"}, rdata[i],   mem_dout[i]);
    if (e_rva[i] || e_rvb[i]) check_eq({p, "rdata"}, rdata[i], refm[i][m_addr[i]]);
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 16'h0010;
      1:       return 16'h7FCE;
      2:       return 16'h7FD0;
      3:       return 16'h7FFE;
      4:       return 16'hFFFF;
      default: return 16'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic new_req(input int i, input bit is_b, input int unsigned pct);
    logic r, w;
    logic [15:0] ad, wd;
    r  = ($urandom_range(0, 99) < pct);
    w  = 1'($urandom_range(0, 1));
    ad = pick_addr();
    wd = 16'($urandom);
    if (is_b) begin b_req[i] = r; b_we[i] = w; b_addr[i] = ad; b_wdata[i] = wd; end
    else      begin a_req[i] = r; a_we[i] = w; a_addr[i] = ad; a_wdata[i] = wd; end
  endtask

  task automatic set_req(input int i, input bit is_b, input logic w,
                         input logic [15:0] ad, input logic [15:0] wd);
    if (is_b) begin b_req[i] = 1'b1; b_we[i] = w; b_addr[i] = ad; b_wdata[i] = wd; end
    else      begin a_req[i] = 1'b1; a_we[i] = w; a_addr[i] = ad; a_wdata[i] = wd; end
  endtask

  // One clock: model and DUT advance on the same edge, outputs compared 1 ns later.
  task automatic step(input bit agents);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      compare_outputs(i);
      if (agents) begin
        if (e_ga[i] || !a_req[i]) new_req(i, 1'b0, e_ga[i] ? 50 : 15);
        if (e_gb[i] || !b_req[i]) new_req(i, 1'b1, e_gb[i] ? 50 : 15);
      end
    end
  endtask

  int ng [2];

  initial begin
    reset = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.rst_busy", i), 16'(busy[i]), 16'h0000);
      check_eq($sformatf("u%0d.rst_addr", i), mem_addr[i], 16'h0000);
      check_eq($sformatf("u%0d.rst_din", i),  mem_din[i],  16'h0000);
    end
    reset = 1'b0;

    // Single write then read-back by A.
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b1, 16'h0010, 16'h1234);
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.wr_gnt", i),  16'(a_gnt[i]),   16'h0001);
      check_eq($sformatf("u%0d.wr_wea", i),  16'(mem_wea[i]), 16'h0001);
      check_eq($sformatf("u%0d.wr_addr", i), mem_addr[i],     16'h0010);
      check_eq($sformatf("u%0d.wr_din", i),  mem_din[i],      16'h1234);
      a_req[i] = 1'b0;
    end
    step(1'b0);
    for (int i = 0; i < 2; i++) check_eq($sformatf("u%0d.wr_busy", i), 16'(busy[i]), 16'h0000);
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 16'h0010, 16'h0000);
    step(1'b0);
    for (int i = 0; i < 2; i++) a_req[i] = 1'b0;
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.rd_rvalid", i),  16'(a_rvalid[i]), 16'h0001);
      check_eq($sformatf("u%0d.rd_data", i),    rdata[i],         16'h1234);
      check_eq($sformatf("u%0d.rd_brvalid", i), 16'(b_rvalid[i]), 16'h0000);
    end
    step(1'b0);

    // B writes into the IO window; A reads it back through the same address.
    for (int i = 0; i < 2; i++) set_req(i, 1'b1, 1'b1, 16'h7FD0, 16'hBEEF);
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.io_gnt", i),  16'(b_gnt[i]),   16'h0001);
      check_eq($sformatf("u%0d.io_addr", i), mem_addr[i],     16'h7FD0);
      check_eq($sformatf("u%0d.io_din", i),  mem_din[i],      16'hBEEF);
      b_req[i] = 1'b0;
    end
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.io_wea_off", i), 16'(mem_wea[i]), 16'h0000);
      set_req(i, 1'b0, 1'b0, 16'h7FD0, 16'h0000);
    end
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.io_rd_addr", i), mem_addr[i], 16'h7FD0);
      a_req[i] = 1'b0;
    end
    step(1'b0);
    for (int i = 0; i < 2; i++) check_eq($sformatf("u%0d.io_rd_data", i), rdata[i], 16'hBEEF);
    step(1'b0);

    // Both requesters hold read requests from reset.
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, 1'b0, 16'h0010, 16'h0000);
      set_req(i, 1'b1, 1'b0, 16'h7FD0, 16'h0000);
      ng[i] = 0;
    end
    for (int s = 0; s < 12; s++) begin
      step(1'b0);
      for (int i = 0; i < 2; i++) begin
        if (a_gnt[i] || b_gnt[i]) begin
          check_eq($sformatf("u%0d.tie_owner%0d", i, ng[i]), 16'(b_gnt[i]),
                   (i == 0) ? 16'(ng[i] % 2) : 16'h0000);
          check_eq($sformatf("u%0d.tie_cycle%0d", i, ng[i]), 16'(s), 16'(3 * ng[i]));
          ng[i]++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.tie_count", i), 16'(ng[i]), 16'h0004);
      a_req[i] = 1'b0;
    end
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.b_after_a_drop", i), 16'(b_gnt[i]), 16'h0001);
      b_req[i] = 1'b0;
    end
    step(1'b0);
    step(1'b0);

    // Reset lands on the ISSUE cycle of a read while B is waiting.
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 16'h0010, 16'h0000);
    step(1'b0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_req[i] = 1'b0;
      set_req(i, 1'b1, 1'b1, 16'h0042, 16'h5555);
    end
    step(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.abort_busy", i),   16'(busy[i]),     16'h0000);
      check_eq($sformatf("u%0d.abort_rvalid", i), 16'(a_rvalid[i]), 16'h0000);
    end
    step(1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.abort_bgnt", i),   16'(b_gnt[i]),    16'h0001);
      check_eq($sformatf("u%0d.abort_rvalid2", i), 16'(a_rvalid[i]), 16'h0000);
      b_req[i] = 1'b0;
    end
    step(1'b0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      step(1'b1);
    end
    reset = 1'b0;
    step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter: RR_ENABLE, 1, 1 = round-robin arbitration, 0 = fixed priority to requester A.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 a_req, a_we  input  1 each  requester A access request and write enable (A is the processor datapath).
REQ-006 a_addr, a_wdata  input  16 each  requester A address and write data.
REQ-007 a_gnt, a_rvalid  output  1 each  requester A grant pulse and read-data-valid pulse.
REQ-008 b_req, b_we, b_addr[15:0], b_wdata[15:0], b_gnt, b_rvalid  SHALL mirror the A ports for requester B (the loader/IO agent).
REQ-009 rdata  output  16  shared read data, qualified by a_rvalid or b_rvalid.
REQ-010 mem_addr, mem_din  output  16 each  address and write data to IO_memblock.
REQ-011 mem_wea  output  1  write enable to IO_memblock.
REQ-012 mem_dout  input  16  IO_memblock data_out; registered, valid one cycle after the address.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE and RDWAIT.
REQ-015 IDLE with no req: stay in IDLE; mem_wea=0.
REQ-016 IDLE with at least one req: select the owner, latch its we/addr/wdata and the owner id, and go to ISSUE.
REQ-017 Selection SHALL be as follows: only one req, that requester wins; both req with RR_ENABLE=1, the requester not served last wins; both req with RR_ENABLE=0, A wins.
REQ-018 The last-served pointer SHALL update only on entry to ISSUE.
REQ-019 ISSUE SHALL assert the owner's gnt for exactly one cycle and drive mem_addr/mem_din from the latched values, with mem_wea equal to the latched we.
REQ-020 ISSUE with latched we=1 SHALL go to IDLE; with we=0 it SHALL go to RDWAIT.
REQ-021 RDWAIT SHALL assert the owner's rvalid for exactly one cycle with rdata=mem_dout, then go to IDLE.
REQ-022 Latency: req seen in IDLE at cycle N gives gnt at N+1; for reads, rvalid at N+2.
REQ-023 A write SHALL occupy 2 cycles and a read 3 cycles, with no back-to-back overlap.
REQ-024 Requesters SHALL hold req/we/addr/wdata stable until gnt and deassert req at the edge ending the gnt cycle.
REQ-025 A req still high in the IDLE cycle after a transaction SHALL be treated as a new request.
REQ-026 mem_wea SHALL be 0 in every state except ISSUE with latched we=1.
REQ-027 mem_addr/mem_din SHALL hold the latched values in RDWAIT and IDLE, so no spurious write occurs.
REQ-028 Addresses SHALL pass through unmodified, including the IO window 0x7FCE..0x7FFE; the arbiter SHALL NOT decode addresses.
REQ-029 rdata SHALL equal mem_dout at all times; it is meaningful only with an rvalid.
REQ-030 a_gnt and b_gnt SHALL never be high together; the same applies to a_rvalid and b_rvalid.

Reset
REQ-031 reset high at a rising edge SHALL force state=IDLE and last-served=B, so A wins the first tie.
REQ-032 During reset, all gnt, all rvalid, mem_wea and busy SHALL be 0.
REQ-033 During reset, mem_addr and mem_din SHALL be 0.
REQ-034 Reset mid-transaction SHALL abort the transaction: no gnt or rvalid afterwards for the aborted access, and mem_wea=0 from the next cycle.
REQ-035 Reset SHALL take priority over all requests in the same cycle.

Verification
REQ-036 Single write: A writes 0x1234 to 0x0010 -> a_gnt at N+1 with mem_wea=1, mem_addr=0x0010, mem_din=0x1234; busy 0 at N+2.
REQ-037 Read-back: A reads 0x0010 -> a_rvalid at N+2 with rdata=0x1234; b_rvalid stays 0.
REQ-038 Contention with RR_ENABLE=1: A and B both hold read req after reset -> grants A, B, A, B in order; each grant 3 cycles apart.
REQ-039 Fixed priority with RR_ENABLE=0: A and B both continuously requesting -> only A is granted while a_req stays high; B is granted in the first IDLE cycle with a_req=0.
REQ-040 IO window: B writes 0xBEEF to 0x7FD0 -> passed through unchanged with mem_wea pulse of 1 cycle; a subsequent A read of 0x7FD0 is issued identically.
REQ-041 Reset in ISSUE of a read -> no rvalid; state IDLE; a pending B req is granted 2 cycles after reset deasserts (IDLE, then ISSUE).
